// File: rtl/counter_pkg.sv
// Shared defaults and saturation-mode encodings for the parameterised counter.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_STEP  = 1;

    // Values for the SATURATE parameter.
    localparam int WRAP = 0;
    localparam int SAT  = 1;

endpackage

// File: rtl/param_counter_reg_if.sv
// Control/status bundle of the counter: load, count, limit in; at_limit, done out.
interface param_counter_reg_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] in;
    logic             in_enable;
    logic             count_enable;
    logic [WIDTH-1:0] limit;
    logic             at_limit;
    logic             done;

    modport master (
        output in, in_enable, count_enable, limit,
        input  at_limit, done
    );

    modport slave (
        input  in, in_enable, count_enable, limit,
        output at_limit, done
    );

endinterface

// File: rtl/sync_dffe.sv
// Single-bit D flip-flop with clock enable; synchronous reset wins over enable.
module sync_dffe (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= 1'b0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/param_counter_reg.sv
// Loadable up-counter that stops at a live limit, with wrap/saturate overflow,
// a registered done pulse and a per-bit tri-state output.
module param_counter_reg
    import counter_pkg::*;
#(
    parameter int          WIDTH    = DEFAULT_WIDTH,
    parameter logic [63:0] STEP     = 64'(DEFAULT_STEP),
    parameter int          SATURATE = WRAP
) (
    input  logic              clock,
    input  logic              reset,
    param_counter_reg_if.slave bus,
    input  logic              out_enable,
    output wire [WIDTH-1:0]   out
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH:0]   sum;
    logic             at_limit;
    logic             count_ok;
    logic             cnt_en;
    logic             done_d;
    logic             done_q;

    assign sum = {1'b0, cnt_q} + STEP_EXT;

    always_comb begin
        step_val = sum[WIDTH-1:0];
        if (sum[WIDTH] && (SATURATE == SAT)) begin
            step_val = '1;
        end
    end

    // A load always wins over counting; counting is blocked while sitting on limit.
    assign at_limit = (cnt_q == bus.limit);
    assign count_ok = bus.count_enable & ~bus.in_enable & ~at_limit;
    assign cnt_en   = bus.in_enable | count_ok;
    assign cnt_d    = bus.in_enable ? bus.in : step_val;
    assign done_d   = count_ok & (step_val == bus.limit);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        sync_dffe u_cnt_bit (
            .clock (clock),
            .reset (reset),
            .en_i  (cnt_en),
            .d_i   (cnt_d[gi]),
            .q_o   (cnt_q[gi])
        );

        assign out[gi] = out_enable ? cnt_q[gi] : 1'bz;
    end

    sync_dffe u_done (
        .clock (clock),
        .reset (reset),
        .en_i  (1'b1),
        .d_i   (done_d),
        .q_o   (done_q)
    );

    assign bus.at_limit = at_limit;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_param_counter_reg.sv
// Directed-vector bench: four counter configurations, expected results queued
// by the stimulus and checked by an independent negedge monitor.
module tb_param_counter_reg;
    import counter_pkg::*;

    typedef struct {
        int          dut;
        bit          rst;
        bit          ld;
        logic [63:0] din;
        bit          ce;
        logic [63:0] lim;
        bit          oe;
        logic [63:0] eout;
        bit          eat;
        bit          edone;
        string       name;
    } row_t;

    typedef struct {
        int          cyc;
        int          dut;
        logic [63:0] eout;
        bit          eat;
        bit          edone;
        string       name;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst0, rst1, rst2, rst3;
    logic oe0, oe1, oe2, oe3;
    wire [31:0] out0;
    wire [7:0]  out1;
    wire [7:0]  out2;
    wire [3:0]  out3;

    // Undriven (high-Z) outputs read back as zero.
    pulldown (out0);
    pulldown (out1);
    pulldown (out2);
    pulldown (out3);

    param_counter_reg_if #(.WIDTH(32)) bus0 ();
    param_counter_reg_if #(.WIDTH(8))  bus1 ();
    param_counter_reg_if #(.WIDTH(8))  bus2 ();
    param_counter_reg_if #(.WIDTH(4))  bus3 ();

    param_counter_reg #(.WIDTH(32), .STEP(64'd1), .SATURATE(WRAP)) dut0 (
        .clock(clock), .reset(rst0), .bus(bus0), .out_enable(oe0), .out(out0));
    param_counter_reg #(.WIDTH(8), .STEP(64'd1), .SATURATE(WRAP)) dut1 (
        .clock(clock), .reset(rst1), .bus(bus1), .out_enable(oe1), .out(out1));
    param_counter_reg #(.WIDTH(8), .STEP(64'd4), .SATURATE(SAT)) dut2 (
        .clock(clock), .reset(rst2), .bus(bus2), .out_enable(oe2), .out(out2));
    param_counter_reg #(.WIDTH(4), .STEP(64'd2), .SATURATE(WRAP)) dut3 (
        .clock(clock), .reset(rst3), .bus(bus3), .out_enable(oe3), .out(out3));

    row_t rows[$];
    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: one observation per queued expectation, in the cycle it targets.
    always @(negedge clock) begin : monitor
        exp_t        e;
        logic [63:0] a_out;
        logic        a_at;
        logic        a_done;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin a_out = 64'(out0); a_at = bus0.at_limit; a_done = bus0.done; end
                1:       begin a_out = 64'(out1); a_at = bus1.at_limit; a_done = bus1.done; end
                2:       begin a_out = 64'(out2); a_at = bus2.at_limit; a_done = bus2.done; end
                default: begin a_out = 64'(out3); a_at = bus3.at_limit; a_done = bus3.done; end
            endcase
            total = total + 3;
            if (a_out !== e.eout) begin
                bad = bad + 1;
                $display("FAIL %s out: got %0h want %0h", e.name, a_out, e.eout);
            end
            if (a_at !== e.eat) begin
                bad = bad + 1;
                $display("FAIL %s at_limit: got %0b want %0b", e.name, a_at, e.eat);
            end
            if (a_done !== e.edone) begin
                bad = bad + 1;
                $display("FAIL %s done: got %0b want %0b", e.name, a_done, e.edone);
            end
            $display("dut%0d %-14s out=%0h at_limit=%0b done=%0b", e.dut, e.name, a_out, a_at, a_done);
        end
    end

    task automatic add(input int d, input bit rs, input bit ld, input logic [63:0] din,
                       input bit ce, input logic [63:0] lim, input bit oe,
                       input logic [63:0] eo, input bit ea, input bit ed, input string nm);
        row_t r;
        r.dut = d;  r.rst = rs; r.ld = ld; r.din = din; r.ce = ce; r.lim = lim; r.oe = oe;
        r.eout = eo; r.eat = ea; r.edone = ed; r.name = nm;
        rows.push_back(r);
    endtask

    task automatic drive(input row_t r);
        case (r.dut)
            0: begin
                rst0 = r.rst; oe0 = r.oe; bus0.in_enable = r.ld; bus0.in = r.din[31:0];
                bus0.count_enable = r.ce; bus0.limit = r.lim[31:0];
            end
            1: begin
                rst1 = r.rst; oe1 = r.oe; bus1.in_enable = r.ld; bus1.in = r.din[7:0];
                bus1.count_enable = r.ce; bus1.limit = r.lim[7:0];
            end
            2: begin
                rst2 = r.rst; oe2 = r.oe; bus2.in_enable = r.ld; bus2.in = r.din[7:0];
                bus2.count_enable = r.ce; bus2.limit = r.lim[7:0];
            end
            default: begin
                rst3 = r.rst; oe3 = r.oe; bus3.in_enable = r.ld; bus3.in = r.din[3:0];
                bus3.count_enable = r.ce; bus3.limit = r.lim[3:0];
            end
        endcase
    endtask

    initial begin
        exp_t e;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        oe0 = 1'b1;  oe1 = 1'b1;  oe2 = 1'b1;  oe3 = 1'b1;
        bus0.in = '0; bus0.in_enable = 1'b0; bus0.count_enable = 1'b0; bus0.limit = '0;
        bus1.in = '0; bus1.in_enable = 1'b0; bus1.count_enable = 1'b0; bus1.limit = '0;
        bus2.in = '0; bus2.in_enable = 1'b0; bus2.count_enable = 1'b0; bus2.limit = '0;
        bus3.in = '0; bus3.in_enable = 1'b0; bus3.count_enable = 1'b0; bus3.limit = '0;

        // dut0: 32-bit, step 1, wrap.   args: dut rst ld din ce lim oe | out at done
        add(0, 1, 0, 0, 0, 0, 1,  0, 1, 0, "rst_lim0");
        add(0, 1, 0, 0, 1, 5, 1,  0, 0, 0, "rst_over_cnt");
        add(0, 0, 0, 0, 1, 5, 1,  1, 0, 0, "cnt1");
        add(0, 0, 0, 0, 1, 5, 1,  2, 0, 0, "cnt2");
        add(0, 0, 0, 0, 1, 5, 1,  3, 0, 0, "cnt3");
        add(0, 0, 0, 0, 1, 5, 1,  4, 0, 0, "cnt4");
        add(0, 0, 0, 0, 1, 5, 1,  5, 1, 1, "cnt5_done");
        add(0, 0, 0, 0, 1, 5, 1,  5, 1, 0, "hold5_a");
        add(0, 0, 0, 0, 1, 5, 1,  5, 1, 0, "hold5_b");
        add(0, 0, 0, 0, 1, 20, 0, 0, 0, 0, "oe_off_6");
        add(0, 0, 0, 0, 1, 20, 0, 0, 0, 0, "oe_off_7");
        add(0, 0, 0, 0, 0, 20, 1, 7, 0, 0, "oe_on_7");
        add(0, 0, 0, 0, 1, 7, 1,  7, 1, 0, "lim_shrink");
        add(0, 0, 0, 0, 1, 8, 1,  8, 1, 1, "lim_grow_done");
        add(0, 0, 1, 4, 0, 10, 1, 4, 0, 0, "load4");
        add(0, 0, 0, 0, 1, 10, 1, 5, 0, 0, "to10_5");
        add(0, 0, 0, 0, 1, 10, 1, 6, 0, 0, "to10_6");
        add(0, 1, 1, 9, 1, 10, 1, 0, 0, 0, "rst_mid");
        add(0, 0, 0, 0, 0, 10, 1, 0, 0, 0, "post_rst");
        add(0, 0, 1, 3, 0, 9, 1,  3, 0, 0, "load3");
        add(0, 0, 1, 9, 1, 9, 1,  9, 1, 0, "load_and_cnt");
        add(0, 0, 0, 0, 1, 9, 1,  9, 1, 0, "hold_at_lim");
        add(0, 0, 1, 2, 0, 9, 1,  2, 0, 0, "load_at_lim");
        // dut1: 8-bit, step 1, wrap
        add(1, 1, 0, 0, 0, 'h10, 1,   0,    0, 0, "w_rst");
        add(1, 0, 1, 'hFE, 0, 'h10, 1, 'hFE, 0, 0, "w_load");
        add(1, 0, 0, 0, 1, 'h10, 1,   'hFF, 0, 0, "w_ff");
        add(1, 0, 0, 0, 1, 'h10, 1,   'h00, 0, 0, "w_wrap");
        add(1, 0, 0, 0, 1, 'h10, 1,   'h01, 0, 0, "w_01");
        add(1, 0, 0, 0, 1, 'h02, 1,   'h02, 1, 1, "w_done");
        // dut2: 8-bit, step 4, saturate
        add(2, 1, 0, 0, 0, 0, 1,        0,    1, 0, "s_rst");
        add(2, 0, 1, 'hFD, 0, 0, 1,     'hFD, 0, 0, "s_load");
        add(2, 0, 0, 0, 1, 0, 1,        'hFF, 0, 0, "s_sat1");
        add(2, 0, 0, 0, 1, 0, 1,        'hFF, 0, 0, "s_sat2");
        add(2, 0, 1, 'hFD, 0, 'hFF, 1,  'hFD, 0, 0, "s_load2");
        add(2, 0, 0, 0, 1, 'hFF, 1,     'hFF, 1, 1, "s_sat_done");
        add(2, 0, 0, 0, 1, 'hFF, 1,     'hFF, 1, 0, "s_hold");
        // dut3: 4-bit, step 2, wrap, odd limit never reached
        add(3, 1, 0, 0, 0, 5, 1, 0, 0, 0, "u_rst");
        for (int k = 1; k <= 10; k++) begin
            add(3, 0, 0, 0, 1, 5, 1, 64'((2 * k) % 16), 0, 0, "u_wrap");
        end

        foreach (rows[i]) begin
            @(negedge clock);
            #1;
            drive(rows[i]);
            e.cyc   = cyc + 1;
            e.dut   = rows[i].dut;
            e.eout  = rows[i].eout;
            e.eat   = rows[i].eat;
            e.edone = rows[i].edone;
            e.name  = rows[i].name;
            sb.push_back(e);
        end

        for (int k = 0; k < 5 && sb.size() > 0; k++) begin
            @(negedge clock);
        end
        #2;
        if (sb.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: got %0d unchecked entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_counter_reg.md
PARAM_COUNTER_REG -- requirements
Module: param_counter_reg

Interface
REQ-001 Parameter WIDTH, default 32, counter and data width in bits (legal range 2..64).
REQ-002 Parameter STEP, default 1, increment per count cycle (1 <= STEP < 2^WIDTH).
REQ-003 Parameter SATURATE, default 0; 0 = wrap modulo 2^WIDTH, 1 = hold at all-ones on overflow.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in  input  WIDTH  load value.
REQ-007 in_enable  input  1  load strobe; captures in on next edge.
REQ-008 count_enable  input  1  advance counter by STEP on next edge.
REQ-009 limit  input  WIDTH  terminal count; sampled every cycle, not registered.
REQ-010 out_enable  input  1  drives out when 1; out is high-Z when 0.
REQ-011 out  output  WIDTH  counter value, tri-state.
REQ-012 at_limit  output  1  combinational level, 1 while counter value == limit.
REQ-013 done  output  1  registered single-cycle pulse on reaching limit by counting.

Function
REQ-014 Next-state priority SHALL be reset > in_enable > count_enable > hold.
REQ-015 Load SHALL set the counter to in on the next edge, regardless of at_limit.
REQ-016 Count SHALL occur only when count_enable=1, in_enable=0 and at_limit=0; the counter stops at limit.
REQ-017 Count SHALL compute the sum in WIDTH+1 bits; on carry-out, SATURATE=0 keeps the low WIDTH bits (wrap) and SATURATE=1 yields all-ones.
REQ-018 A counter already at all-ones with SATURATE=1 and count accepted SHALL hold all-ones, with no done unless limit is all-ones.
REQ-019 done SHALL be 1 in exactly the cycle after an edge where a count step made the counter equal to limit; it is 0 otherwise.
REQ-020 Reaching limit by load or reset SHALL NOT assert done; at_limit still reflects equality.
REQ-021 Simultaneous in_enable and count_enable SHALL perform the load only, with done=0 next cycle.
REQ-022 A limit change mid-count SHALL take effect immediately for at_limit and count gating.
REQ-023 Unreachable limit (e.g. STEP=2, odd limit, wrap mode) SHALL count and wrap indefinitely without done.
REQ-024 out_enable SHALL affect only out; the counter, at_limit and done are independent of it.
REQ-025 Latency SHALL be 1 cycle from accepted load/count to the new value on out.

Reset
REQ-026 reset=1 at an edge SHALL clear the counter to 0 and done to 0, overriding load and count.
REQ-027 Reset mid-count SHALL abandon the count with no done pulse.
REQ-028 After reset, out SHALL be 0 when out_enable=1, and at_limit SHALL be (limit==0).
REQ-029 No asynchronous reset path SHALL exist.

Structure
REQ-030 Shared package counter_pkg SHALL hold DEFAULT_WIDTH=32, DEFAULT_STEP=1 and the SATURATE mode encodings WRAP=0 and SAT=1.
REQ-031 Storage SHALL be WIDTH instances of sub-module sync_dffe (D, clock, enable, synchronous reset, Q), built with a generate loop.
REQ-032 The done flag SHALL be a separate sync_dffe instance.
REQ-033 The tri-state driver SHALL be per-bit, at the top level only.

Verification
REQ-034 WIDTH=32, STEP=1: reset, limit=5, count_enable=1 held -> out goes 1,2,3,4,5, then holds 5; done high only the cycle out first reads 5.
REQ-035 WIDTH=8, SATURATE=0: load 0xFE, count 3 cycles with limit=0x10 -> 0xFF, 0x00, 0x01, with no done.
REQ-036 WIDTH=8, SATURATE=1, STEP=4: load 0xFD, count 2 cycles with limit=0x00 -> 0xFF, 0xFF, with no done.
REQ-037 Load and count together: counter at 3, in=9, limit=9 -> out=9, at_limit=1, done stays 0.
REQ-038 Reset mid-count: counting toward limit=10, assert reset at value 6 with in_enable=1 -> out=0 next cycle, done never asserts.
REQ-039 out_enable=0 during counting -> out all-Z, internal counting continues; on re-enable, out shows the current count.
